// File: rtl/fft_stream_pkg.sv
// ---------------------------------------------------------------------------
// fft_stream_pkg
//   Shared types and constants for the FFT bin streamer.
//
//   cbin_t         : one complex FFT bin, {im[31:16], re[15:0]}
//   fifo_entry_t   : one buffered beat, {last, bin}
//   stream_state_t : alignment FSM states (STREAM, RESYNC)
// ---------------------------------------------------------------------------
package fft_stream_pkg;

    localparam int NUM_MICS = 4;
    localparam int BIN_W    = 32;
    localparam int ENTRY_W  = BIN_W + 1;
    localparam int WORD_W   = NUM_MICS * BIN_W;

    typedef struct packed {
        logic signed [15:0] im;
        logic signed [15:0] re;
    } cbin_t;

    typedef struct packed {
        logic  last;
        cbin_t bin;
    } fifo_entry_t;

    typedef enum logic {
        STREAM = 1'b0,
        RESYNC = 1'b1
    } stream_state_t;

endpackage : fft_stream_pkg

// File: rtl/bin_fifo.sv
// ---------------------------------------------------------------------------
// bin_fifo
//   Single-clock FIFO holding one channel's FFT beats. The head entry is
//   presented combinationally on data_out whenever empty_out is low.
//
//   clk_in     : clock
//   rst_in     : synchronous active-high reset (empties the FIFO)
//   push_in    : write data_in (ignored when full unless popping too)
//   data_in    : entry to write
//   pop_in     : discard the head entry (ignored when empty)
//   data_out   : head entry
//   full_out   : DEPTH entries stored
//   empty_out  : no entries stored
// ---------------------------------------------------------------------------
module bin_fifo
    import fft_stream_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full_out,
    output logic             empty_out
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign full_out  = (r_count == (AW+1)'(DEPTH));
    assign empty_out = (r_count == '0);

    // A push while full is only safe when the head leaves in the same cycle.
    assign w_push = push_in && (!full_out || pop_in);
    assign w_pop  = pop_in && !empty_out;

    assign data_out = r_mem[r_rd_ptr];

    // NOTE: the storage array has no reset; occupancy is tracked by r_count,
    // so stale contents are never observed and the array can map to RAM.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : bin_fifo

// File: rtl/fft_bin_streamer.sv
// ---------------------------------------------------------------------------
// fft_bin_streamer
//   Realigns four per-microphone FFT streams bin by bin, drops bins outside
//   [BIN_LO, BIN_HI] and forwards one 128-bit word per in-band bin over a
//   valid/ready handshake. A mismatch between the channels' frame markers
//   and the local bin counter triggers a resynchronisation to the next frame
//   boundary of every channel.
//
//   clk_in          : clock
//   rst_in          : synchronous active-high reset
//   mic_data_in     : per-mic bin {im, re}
//   mic_valid_in    : per-mic beat valid
//   mic_last_in     : per-mic last bin of frame
//   mic_ready_out   : per-mic ready (FIFO not full)
//   data_out        : {mic3, mic2, mic1, mic0}
//   valid_out       : data_out valid
//   ready_in        : downstream ready
//   bin_out         : bin index of data_out
//   last_out        : data_out carries bin BIN_HI
//   frame_count_out : completed aligned frames (wraps)
//   desync_out      : one-cycle pulse on detected misalignment
// ---------------------------------------------------------------------------
module fft_bin_streamer
    import fft_stream_pkg::*;
#(
    parameter  int FFT_LEN    = 1024,
    parameter  int BIN_LO     = 8,
    parameter  int BIN_HI     = 64,
    parameter  int FIFO_DEPTH = 16,
    localparam int BW         = $clog2(FFT_LEN)
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_MICS-1:0][BIN_W-1:0] mic_data_in,
    input  logic [NUM_MICS-1:0]            mic_valid_in,
    input  logic [NUM_MICS-1:0]            mic_last_in,
    output logic [NUM_MICS-1:0]            mic_ready_out,
    output logic [WORD_W-1:0]              data_out,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic [BW-1:0]                  bin_out,
    output logic                           last_out,
    output logic [15:0]                    frame_count_out,
    output logic                           desync_out
);

    localparam logic [BW-1:0] LO_BIN  = BW'(BIN_LO);
    localparam logic [BW-1:0] HI_BIN  = BW'(BIN_HI);
    localparam logic [BW-1:0] END_BIN = BW'(FFT_LEN - 1);

    // -----------------------------------------------------------------------
    // Per-channel input buffering
    // -----------------------------------------------------------------------
    fifo_entry_t                    w_head [NUM_MICS];
    logic [NUM_MICS-1:0]            w_full;
    logic [NUM_MICS-1:0]            w_empty;
    logic [NUM_MICS-1:0]            w_push;
    logic [NUM_MICS-1:0]            w_pop;
    logic [NUM_MICS-1:0]            w_head_last;
    logic [NUM_MICS-1:0][BIN_W-1:0] w_word;

    for (genvar g = 0; g < NUM_MICS; g++) begin : g_chan
        assign w_push[g]      = mic_valid_in[g] && !w_full[g];
        assign w_head_last[g] = w_head[g].last;
        assign w_word[g]      = w_head[g].bin;

        bin_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .push_in   (w_push[g]),
            .data_in   ({mic_last_in[g], mic_data_in[g]}),
            .pop_in    (w_pop[g]),
            .data_out  (w_head[g]),
            .full_out  (w_full[g]),
            .empty_out (w_empty[g])
        );
    end

    assign mic_ready_out = ~w_full;

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    stream_state_t       r_state;
    logic [BW-1:0]       r_bin;
    logic [NUM_MICS-1:0] r_done;
    logic [15:0]         r_frame_count;
    logic                r_desync;
    logic                r_valid;
    logic [WORD_W-1:0]   r_data;
    logic [BW-1:0]       r_bin_out;
    logic                r_last;

    // -----------------------------------------------------------------------
    // Joint pop / error detection
    // -----------------------------------------------------------------------
    logic                w_can_load;
    logic                w_in_band;
    logic                w_bin_is_end;
    logic                w_all_avail;
    logic                w_joint_pop;
    logic                w_err;
    logic                w_forward;
    logic [NUM_MICS-1:0] w_resync_pop;
    logic [NUM_MICS-1:0] w_done_next;

    assign w_can_load   = !r_valid || ready_in;
    assign w_in_band    = (r_bin >= LO_BIN) && (r_bin <= HI_BIN);
    assign w_bin_is_end = (r_bin == END_BIN);
    assign w_all_avail  = (w_empty == '0);

    // Out-of-band bins are discarded, so they never wait for the output slot.
    assign w_joint_pop = (r_state == STREAM) && w_all_avail
                         && (w_can_load || !w_in_band);

    // Every head's frame marker must match the local counter; this also
    // covers the case of the channels disagreeing among themselves.
    assign w_err = (w_head_last != {NUM_MICS{w_bin_is_end}});

    assign w_forward = w_joint_pop && !w_err && w_in_band;

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_resync_pop = '0;
        w_pop        = '0;
        if (r_state == RESYNC) begin
            w_resync_pop = ~r_done & ~w_empty;
        end
        if (w_joint_pop) begin
            w_pop = '1;
        end else begin
            w_pop = w_resync_pop;
        end
        w_done_next = r_done | (w_resync_pop & w_head_last);
    end

    // -----------------------------------------------------------------------
    // FSM, bin counter and output register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= STREAM;
            r_bin         <= '0;
            r_done        <= '0;
            r_frame_count <= '0;
            r_desync      <= 1'b0;
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_bin_out     <= '0;
            r_last        <= 1'b0;
        end else begin
            r_desync <= 1'b0;

            // Output slot keeps draining in both FSM states.
            if (w_can_load) begin
                r_valid <= w_forward;
                if (w_forward) begin
                    r_data    <= w_word;
                    r_bin_out <= r_bin;
                    r_last    <= (r_bin == HI_BIN);
                end
            end

            case (r_state)
                STREAM: begin
                    if (w_joint_pop) begin
                        if (w_err) begin
                            r_desync <= 1'b1;
                            // A channel whose erroneous head was a frame end
                            // is already at a boundary and needs no flushing.
                            r_done   <= w_head_last;
                            r_state  <= RESYNC;
                        end else begin
                            r_bin <= r_bin + 1'b1;
                            if (w_bin_is_end) begin
                                r_frame_count <= r_frame_count + 16'd1;
                            end
                        end
                    end
                end

                RESYNC: begin
                    if (&w_done_next) begin
                        r_done  <= '0;
                        r_bin   <= '0;
                        r_state <= STREAM;
                    end else begin
                        r_done <= w_done_next;
                    end
                end

                default: begin
                    r_state <= STREAM;
                end
            endcase
        end
    end

    assign data_out        = r_data;
    assign valid_out       = r_valid;
    assign bin_out         = r_bin_out;
    assign last_out        = r_last;
    assign frame_count_out = r_frame_count;
    assign desync_out      = r_desync;

endmodule : fft_bin_streamer

// File: tb/tb_fft_bin_streamer.sv
// ---------------------------------------------------------------------------
// tb_fft_bin_streamer
//   Randomised traffic against a frame-level reference model of the streamer.
// ---------------------------------------------------------------------------
module tb_fft_bin_streamer;

    localparam int FFT_LEN    = 16;
    localparam int BIN_LO     = 2;
    localparam int BIN_HI     = 5;
    localparam int FIFO_DEPTH = 16;
    localparam int BW         = $clog2(FFT_LEN);
    localparam int NM         = 4;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic [NM-1:0][31:0]  mic_data_in;
    logic [NM-1:0]        mic_valid_in;
    logic [NM-1:0]        mic_last_in;
    logic [NM-1:0]        mic_ready_out;
    logic [127:0]         data_out;
    logic                 valid_out;
    logic                 ready_in;
    logic [BW-1:0]        bin_out;
    logic                 last_out;
    logic [15:0]          frame_count_out;
    logic                 desync_out;

    fft_bin_streamer #(
        .FFT_LEN    (FFT_LEN),
        .BIN_LO     (BIN_LO),
        .BIN_HI     (BIN_HI),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .mic_data_in     (mic_data_in),
        .mic_valid_in    (mic_valid_in),
        .mic_last_in     (mic_last_in),
        .mic_ready_out   (mic_ready_out),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .bin_out         (bin_out),
        .last_out        (last_out),
        .frame_count_out (frame_count_out),
        .desync_out      (desync_out)
    );

    always #5 clk_in = ~clk_in;

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus streams and reference model
    // -----------------------------------------------------------------------
    typedef struct {
        logic [127:0]  data;
        logic [BW-1:0] bin;
        logic          last;
    } word_t;

    logic [32:0] stim_q [NM][$];
    word_t       exp_q[$];
    word_t       obs_q[$];
    int          exp_frames;
    int          exp_desync;
    int          obs_desync;

    // Each mic sends n_frames frames of FFT_LEN bins; optionally one beat of
    // one mic is dropped to create a misalignment.
    task automatic build_stream(input int n_frames, input bit pattern,
                                input int drop_mic, input int drop_frame, input int drop_bin);
        for (int m = 0; m < NM; m++) begin
            stim_q[m].delete();
            for (int f = 0; f < n_frames; f++) begin
                for (int b = 0; b < FFT_LEN; b++) begin
                    logic [31:0] d;
                    if (m == drop_mic && f == drop_frame && b == drop_bin) continue;
                    d = pattern ? 32'(32'h1000 * m + b) : $urandom;
                    stim_q[m].push_back({(b == FFT_LEN - 1), d});
                end
            end
        end
    endtask

    // Walks the four streams as a sequence of aligned bins: every step takes
    // one beat from each mic. A frame-marker mismatch discards each mic up to
    // and including its next frame end and restarts counting at bin 0.
    function automatic void compute_model();
        int          idx[NM];
        int          bin;
        bit          run;
        logic [NM-1:0] lasts;
        logic [127:0]  w;
        exp_q.delete();
        exp_frames = 0;
        exp_desync = 0;
        bin        = 0;
        run        = 1'b1;
        for (int m = 0; m < NM; m++) idx[m] = 0;
        while (run) begin
            for (int m = 0; m < NM; m++)
                if (idx[m] >= stim_q[m].size()) run = 1'b0;
            if (!run) break;
            for (int m = 0; m < NM; m++) begin
                lasts[m]      = stim_q[m][idx[m]][32];
                w[m*32 +: 32] = stim_q[m][idx[m]][31:0];
                idx[m]++;
            end
            if (lasts != {NM{bin == FFT_LEN - 1}}) begin
                exp_desync++;
                bin = 0;
                for (int m = 0; m < NM; m++) begin
                    bit found;
                    found = lasts[m];
                    while (!found && idx[m] < stim_q[m].size()) begin
                        found = stim_q[m][idx[m]][32];
                        idx[m]++;
                    end
                    if (!found) run = 1'b0;
                end
            end else begin
                if (bin >= BIN_LO && bin <= BIN_HI)
                    exp_q.push_back('{w, bin[BW-1:0], (bin == BIN_HI)});
                bin++;
                if (bin == FFT_LEN) begin
                    bin = 0;
                    exp_frames++;
                end
            end
        end
    endfunction

    // -----------------------------------------------------------------------
    // Per-cycle driver / monitor (runs at the falling edge)
    // -----------------------------------------------------------------------
    int           ptr[NM];
    bit           pres[NM];
    int           vmode[NM];
    int           delay[NM];
    int           rmode;
    int           cyc;
    int           stall_left;
    bit           stall_done;
    bit           saw_full;
    bit           prev_valid;
    bit           prev_ready;
    logic [127:0] prev_data;
    logic [BW-1:0] prev_bin;
    logic         prev_last;

    task automatic init_drivers();
        for (int m = 0; m < NM; m++) begin
            ptr[m]  = 0;
            pres[m] = 1'b0;
        end
        cyc        = 0;
        stall_left = 0;
        stall_done = 1'b0;
        saw_full   = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
        obs_q.delete();
        obs_desync = 0;
    endtask

    function automatic bit want(input int m);
        if (cyc < delay[m]) return 1'b0;
        case (vmode[m])
            0:       return 1'b1;
            1:       return ($urandom_range(0, 9) < 7);
            default: return ((cyc % 16) < 8);
        endcase
    endfunction

    function automatic bit all_sent();
        for (int m = 0; m < NM; m++)
            if (ptr[m] < stim_q[m].size() || pres[m]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic step();
        cyc++;
        case (rmode)
            0: ready_in = 1'b1;
            1: ready_in = ($urandom_range(0, 4) != 0);
            default: begin
                if (!stall_done && valid_out && bin_out == 3 && obs_q.size() >= 4) begin
                    stall_left = 20;
                    stall_done = 1'b1;
                end
                if (stall_left > 0) begin
                    ready_in = 1'b0;
                    stall_left--;
                    if (mic_ready_out == '0) saw_full = 1'b1;
                end else begin
                    ready_in = 1'b1;
                end
            end
        endcase

        if (prev_valid && !prev_ready) begin
            check("hold_valid", valid_out, 1'b1);
            check("hold_data", data_out, prev_data);
            check("hold_bin", bin_out, prev_bin);
            check("hold_last", last_out, prev_last);
        end
        prev_valid = valid_out;
        prev_ready = ready_in;
        prev_data  = data_out;
        prev_bin   = bin_out;
        prev_last  = last_out;

        if (desync_out) obs_desync++;
        if (valid_out && ready_in) obs_q.push_back('{data_out, bin_out, last_out});

        for (int m = 0; m < NM; m++) begin
            if (!pres[m]) begin
                if (ptr[m] < stim_q[m].size() && want(m)) begin
                    pres[m] = 1'b1;
                    {mic_last_in[m], mic_data_in[m]} = stim_q[m][ptr[m]];
                    mic_valid_in[m] = 1'b1;
                end else begin
                    mic_valid_in[m] = 1'b0;
                end
            end
            // Ready is stable until the next rising edge, so acceptance is known now.
            if (pres[m] && mic_ready_out[m]) begin
                ptr[m]++;
                pres[m] = 1'b0;
            end
        end
    endtask

    task automatic apply_reset();
        rst_in       = 1'b1;
        mic_valid_in = '0;
        mic_last_in  = '0;
        mic_data_in  = '0;
        ready_in     = 1'b1;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        check("rst_valid", valid_out, 1'b0);
        check("rst_data", data_out, 128'h0);
        check("rst_bin", bin_out, 0);
        check("rst_last", last_out, 1'b0);
        check("rst_frames", frame_count_out, 16'h0);
        check("rst_desync", desync_out, 1'b0);
        check("rst_mic_ready", mic_ready_out, 4'b1111);
    endtask

    task automatic run_traffic(input string sc, input bit do_reset);
        int tail;
        if (do_reset) apply_reset();
        init_drivers();
        compute_model();
        tail = 0;
        for (int c = 0; c < 4000 && tail < 40; c++) begin
            @(negedge clk_in);
            step();
            if (all_sent() && obs_q.size() >= exp_q.size()) tail++;
        end
        check({sc, "_word_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s_w%0d_data", sc, i), obs_q[i].data, exp_q[i].data);
            check($sformatf("%s_w%0d_bin", sc, i), obs_q[i].bin, exp_q[i].bin);
            check($sformatf("%s_w%0d_last", sc, i), obs_q[i].last, exp_q[i].last);
        end
        check({sc, "_desync"}, obs_desync, exp_desync);
        check({sc, "_frames"}, frame_count_out, exp_frames[15:0]);
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    initial begin
        bit hit;

        // Aligned frames with counting pattern and ready held high.
        build_stream(3, 1'b1, -1, -1, -1);
        vmode = '{0, 0, 0, 0};
        delay = '{0, 0, 0, 0};
        rmode = 0;
        run_traffic("aligned", 1'b1);
        check("aligned_expected_words", exp_q.size(), 12);
        if (obs_q.size() > 0) begin
            check("aligned_first_data", obs_q[0].data, 128'h00003002_00002002_00001002_00000002);
            check("aligned_first_bin", obs_q[0].bin, 2);
        end
        check("aligned_frame_count", frame_count_out, 16'd3);

        // Skewed arrival: mic2 late, mic3 bursty.
        build_stream(3, 1'b1, -1, -1, -1);
        vmode = '{0, 0, 0, 2};
        delay = '{0, 0, 5, 0};
        run_traffic("skewed", 1'b1);
        check("skewed_no_desync", obs_desync, 0);

        // Backpressure: 20-cycle stall in the middle of the band.
        build_stream(4, 1'b0, -1, -1, -1);
        vmode = '{0, 0, 0, 0};
        delay = '{0, 0, 0, 0};
        rmode = 2;
        run_traffic("backpressure", 1'b1);
        check("backpressure_fifo_full_seen", saw_full, 1'b1);

        // Desync: mic1 loses one beat of the second frame.
        build_stream(5, 1'b0, 1, 1, 3);
        vmode = '{1, 1, 1, 1};
        rmode = 1;
        run_traffic("desync", 1'b1);
        check("desync_one_pulse", obs_desync, 1);
        check("desync_frame_count", frame_count_out, 16'd4);

        // Random traffic, optionally with a dropped beat.
        for (int r = 0; r < 4; r++) begin
            int nf;
            nf = $urandom_range(3, 6);
            if ($urandom_range(0, 1) == 1)
                build_stream(nf, 1'b0, $urandom_range(0, NM - 1), $urandom_range(1, nf - 2),
                             $urandom_range(0, FFT_LEN - 1));
            else
                build_stream(nf, 1'b0, -1, -1, -1);
            for (int m = 0; m < NM; m++) begin
                vmode[m] = $urandom_range(0, 2);
                delay[m] = $urandom_range(0, 8);
            end
            rmode = 1;
            run_traffic($sformatf("random%0d", r), 1'b1);
        end

        // Reset mid-frame while bin 3 is on the output.
        build_stream(2, 1'b1, -1, -1, -1);
        vmode = '{0, 0, 0, 0};
        delay = '{0, 0, 0, 0};
        rmode = 0;
        apply_reset();
        init_drivers();
        hit = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_in);
            if (valid_out && bin_out == 3) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        check("midreset_reached_bin3", hit, 1'b1);
        rst_in       = 1'b1;
        mic_valid_in = '0;
        @(negedge clk_in);
        check("midreset_valid", valid_out, 1'b0);
        check("midreset_frames", frame_count_out, 16'h0);
        check("midreset_bin", bin_out, 0);
        check("midreset_mic_ready", mic_ready_out, 4'b1111);
        rst_in = 1'b0;
        build_stream(1, 1'b1, -1, -1, -1);
        run_traffic("after_reset", 1'b0);
        if (obs_q.size() > 0) begin
            check("after_reset_first_bin", obs_q[0].bin, 2);
            check("after_reset_first_data", obs_q[0].data, 128'h00003002_00002002_00001002_00000002);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fft_bin_streamer

// File: doc/fft_bin_streamer.md
Name: fft_bin_streamer

Overview:
Transmit side of the localizer's FFT input interface. Takes four per-microphone FFT output streams (mic0 = central, mic1-3 = peripheral). Realigns them bin by bin and drops bins outside the band of interest. Emits one 128-bit word per in-band bin into the localizer over a valid/ready handshake, and detects and recovers from channel desynchronisation.

Parameters:
FFT_LEN, 1024, bins per frame (power of two); bin index width BW = $clog2(FFT_LEN)
BIN_LO, 8, first forwarded bin (inclusive)
BIN_HI, 64, last forwarded bin (inclusive); must satisfy BIN_LO <= BIN_HI < FFT_LEN
FIFO_DEPTH, 16, per-channel FIFO entries (power of two, >= 4)

Ports:
clk_in  in  1  clock
rst_in  in  1  reset
mic_data_in  in  4x32  per-mic FFT bin, each {im[31:16], re[15:0]}
mic_valid_in  in  4  per-mic beat valid
mic_last_in  in  4  per-mic last bin of frame
mic_ready_out  out  4  per-mic ready (FIFO not full)
data_out  out  128  {mic3, mic2, mic1, mic0}, mic0 in [31:0]
valid_out  out  1  data_out valid
ready_in  in  1  downstream ready (localizer_ready_out)
bin_out  out  BW  bin index of data_out
last_out  out  1  data_out carries bin BIN_HI
frame_count_out  out  16  completed aligned frames, wraps
desync_out  out  1  one-cycle pulse on detected misalignment

Behaviour:
- Single clock clk_in; reset synchronous, active-high on rst_in.
- Reset state: FIFOs empty, valid_out=0, data_out=0, bin_out=0, last_out=0, frame_count_out=0, desync_out=0, bin counter=0, FSM=STREAM. mic_ready_out=4'b1111 from the first cycle after reset.
- Reset mid-operation discards all buffered and held data. No partial output is produced afterwards.
- Input side: channel i accepts a beat when mic_valid_in[i] && mic_ready_out[i], storing {last, data}. mic_ready_out[i] = !full[i]. Each channel is independent.
- Output register: loads when (!valid_out || ready_in). It holds data_out, bin_out and last_out stable while valid_out && !ready_in.
- Beat accepted at edge N is at the FIFO head after N. It can reach valid_out after edge N+1, so minimum latency is 2 cycles.
- Full throughput is 1 word/cycle with ready_in held high.
- FSM STREAM:
  - Joint pop when all four FIFOs are non-empty and the pop condition holds. The pop condition is: the output register can load, or the bin is out of band.
  - Out-of-band bins are popped without stalling on ready_in.
  - In band means BIN_LO <= bin <= BIN_HI. An in-band pop loads the output register with bin_out = bin and last_out = (bin == BIN_HI).
  - Bin counter increments per joint pop. It wraps to 0 after FFT_LEN-1, and frame_count_out increments on that pop.
  - Error check on every joint pop: the four head last flags disagree, or any last flag differs from (bin == FFT_LEN-1).
  - On error: pulse desync_out, do not forward the popped word, go to RESYNC.
- FSM RESYNC:
  - Each channel pops independently, one entry per cycle when non-empty, until it pops an entry with last=1. That channel's done flag is then set and it stops popping.
  - When all four done flags are set: clear the flags, bin counter=0, return to STREAM. frame_count_out is unchanged.
  - The output register still drains normally during RESYNC.
  - Input acceptance continues in every state.
- Simultaneous push and pop on a FIFO keeps occupancy unchanged and is legal when full.
- Reading an empty FIFO never occurs.
- Arithmetic: data is passed through bit-exact, with no sign extension or scaling.

Decomposition:
- Package fft_stream_pkg:
  - typedef for a complex bin (struct {logic signed [15:0] im, re;}, 32 bits)
  - NUM_MICS=4, word width 128
  - FSM enum {STREAM, RESYNC}
- Sub-module bin_fifo: synchronous FIFO, 33-bit entries, FIFO_DEPTH, with full/empty/push/pop. Instantiated four times.

Test Plan:
- Aligned frames: FFT_LEN=16, BIN_LO=2, BIN_HI=5, bins carry value 0x1000*mic+bin, ready_in=1 -> exactly 4 words per frame; first word 0x00003002_00002002_00001002_00000002 with bin_out=2; last_out=1 on bin 5; frame_count_out increments once per frame.
- Skewed arrival: mic2 delayed 5 cycles, mic3 sent in bursts -> output identical to the aligned case; no desync_out.
- Backpressure: ready_in low for 20 cycles mid-band -> data_out held stable; mic_ready_out drops once each FIFO holds 16 entries; no data lost or duplicated after release.
- Desync: mic1 drops one beat in frame 2 -> one desync_out pulse; output resumes at bin_out=BIN_LO on the next frame boundary of all channels; frame_count_out not incremented for the corrupted frame.
- Reset mid-frame at bin 3 with valid_out high -> next cycle valid_out=0 and counters 0; the following clean frame is forwarded correctly starting at bin_out=2.
